// File: rtl/key_event_reader.sv
// key_event_reader: debounced key inputs queued as events, read over MemBus.
// Optional: define KEY_RELEASE_EVENT_EN to queue release edges as well.
module key_event_reader #(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [31:0]        MemBus_Address,
  input  logic [31:0]        MemBus_Write_Data,
  output logic [31:0]        Device_Read_Data,
  output logic               key_irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [31:0] A_STATUS = 32'h4000_0020;
  localparam logic [31:0] A_DATA   = 32'h4000_0024;
  localparam logic [31:0] A_LEVEL  = 32'h4000_0028;

`ifdef KEY_RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic [KEY_NUM-1:0] sync1_q, sync1_d;
  logic [KEY_NUM-1:0] sync2_q, sync2_d;
  logic [KEY_NUM-1:0] level_q, level_d;
  logic [KEY_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_NUM-1:0] pend_q, pend_d;
  logic [KEY_NUM-1:0] dir_q, dir_d;

  logic [FIFO_DEPTH-1:0][3:0] mem_q, mem_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [KEY_NUM-1:0] flip;
  logic [KEY_NUM-1:0] gnt;
  logic               found;
  logic [2:0]         sel_idx;
  logic               sel_dir;

  logic sel_status, sel_data, sel_level;
  logic empty, full, push, pop, do_write, drop;
  logic [3:0] head;
  logic [7:0] cnt8;
  logic unused_bits;

  assign sel_status = (MemBus_Address == A_STATUS);
  assign sel_data   = (MemBus_Address == A_DATA);
  assign sel_level  = (MemBus_Address == A_LEVEL);

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign push     = found;
  assign pop      = MemRead && sel_data && !empty;
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign head     = mem_q[rptr_q];
  assign cnt8     = 8'(count_q);
  assign key_irq  = !empty;

  assign unused_bits = ^{MemBus_Write_Data[31:2],
                         MemBus_Write_Data[0], cnt8[7:4]};

  // two-flop synchronizer for the raw key levels
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
  end

  // per-key stability counter; flips the level after a full stable run
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    flip    = '0;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (sync2_q[k] != level_q[k]) begin
        if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[k] = sync2_q[k];
          cnt_d[k]   = '0;
          flip[k]    = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  // fixed-priority grant: lowest-index pending key wins
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    sel_idx = '0;
    sel_dir = 1'b0;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (pend_q[k] && !found) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        sel_idx = 3'(k);
        sel_dir = dir_q[k];
      end
    end
  end

  // pending flags: serviced keys clear, fresh edges set (fresh wins)
  always_comb begin
    pend_d = pend_q & ~gnt;
    dir_d  = dir_q;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (flip[k] && (REL_EN || sync2_q[k])) begin
        pend_d[k] = 1'b1;
        dir_d[k]  = sync2_q[k];
      end
    end
  end

  // event FIFO pointers, occupancy and sticky overflow
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (do_write) begin
      mem_d[wptr_q] = {sel_dir, sel_idx};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_write) - CW'(pop);
    if (MemWrite && sel_status && MemBus_Write_Data[1]) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // read mux, combinational from strobe and address
  always_comb begin
    Device_Read_Data = '0;
    if (MemRead) begin
      unique case (1'b1)
        sel_status: Device_Read_Data =
          {24'd0, cnt8[3:0], 1'b0, full, ovf_q, !empty};
        sel_data: if (!empty) Device_Read_Data =
          {1'b1, 22'd0, head[3], 5'd0, head[2:0]};
        sel_level: Device_Read_Data = 32'(level_q);
        default: Device_Read_Data = '0;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      dir_q   <= '0;
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_key_event_reader.sv
// tb_key_event_reader: directed reads checked by a scoreboard monitor.
// Read expectations are queued by stimulus and consumed on each MemRead.
module tb_key_event_reader;

  localparam logic [31:0] A_STATUS = 32'h4000_0020;
  localparam logic [31:0] A_DATA   = 32'h4000_0024;
  localparam logic [31:0] A_LEVEL  = 32'h4000_0028;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key_in = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] MemBus_Address = '0;
  logic [31:0] MemBus_Write_Data = '0;
  logic [31:0] Device_Read_Data;
  logic        key_irq;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  key_event_reader dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .MemBus_Address(MemBus_Address),
    .MemBus_Write_Data(MemBus_Write_Data),
    .Device_Read_Data(Device_Read_Data),
    .key_irq(key_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (MemRead) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: got %h, required no read",
                 Device_Read_Data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Device_Read_Data !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h, required %h",
                   e.nm, Device_Read_Data, e.exp);
        end
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    x.nm = nm;
    x.exp = e;
    sb.push_back(x);
    MemRead = 1'b1;
    MemBus_Address = a;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    MemBus_Address = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    MemWrite = 1'b1;
    MemBus_Address = a;
    MemBus_Write_Data = d;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemBus_Address = '0;
    MemBus_Write_Data = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(3);
    reset = 1'b1;
    idle(2);
    chk("rst_irq", 32'(key_irq), 0);
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_DATA, 32'h0, "rst_data_empty");

    // key 2 press: level flips on edge 22 after the change
    @(posedge clk);
    #1;
    key_in = 4'b0100;
    repeat (20) @(posedge clk);
    rd(A_LEVEL, 32'h0, "k2_level_early");
    rd(A_LEVEL, 32'h4, "k2_level_22");
    rd(A_STATUS, 32'h11, "k2_status");
    chk("k2_irq", 32'(key_irq), 1);
    rd(A_DATA, 32'h8000_0102, "k2_data");
    rd(A_STATUS, 32'h0, "k2_status_after");
    chk("k2_irq_after", 32'(key_irq), 0);

    // key 1 bounces every 5 cycles, then settles high
    for (int i = 0; i < 20; i++) begin
      key_in[1] = ~key_in[1];
      idle(5);
    end
    key_in[1] = 1'b1;
    rd(A_STATUS, 32'h0, "bounce_status");
    rd(A_DATA, 32'h0, "bounce_data");
    idle(30);
    rd(A_STATUS, 32'h11, "k1_status");
    rd(A_DATA, 32'h8000_0101, "k1_data");
    rd(A_LEVEL, 32'h6, "k1_level");

    // keys 0 and 3 together: queued in index order
    key_in = key_in | 4'b1001;
    idle(30);
    rd(A_DATA, 32'h8000_0100, "k03_first");
    rd(A_DATA, 32'h8000_0103, "k03_second");
    rd(A_STATUS, 32'h0, "k03_status");
    rd(A_LEVEL, 32'hF, "k03_level");

    // reset with keys held: presses re-emitted at cycle 23
    reset = 1'b0;
    rd(A_LEVEL, 32'h0, "inrst_level");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    rd(A_LEVEL, 32'h0, "rerst_level_early");
    rd(A_STATUS, 32'h11, "rerst_status_23");
    idle(10);
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, 32'h8000_0100 | 32'(i), "rerst_data");
    end
    chk("rerst_irq", 32'(key_irq), 0);

    // overflow: release all, press all, then two more edges
    key_in = 4'b0000;
    idle(30);
`ifdef KEY_RELEASE_EVENT_EN
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, 32'h8000_0000 | 32'(i), "rel_all_data");
    end
`endif
    rd(A_STATUS, 32'h0, "rel_all_status");
    key_in = 4'b1111;
    idle(30);
    rd(A_STATUS, 32'h45, "full_status");
    key_in = 4'b1110;
    idle(30);
    key_in = 4'b1111;
    idle(30);
    rd(A_STATUS, 32'h47, "ovf_status");
    rd(32'h4000_0060, 32'h0, "other_addr");
    rd(32'h4000_0025, 32'h0, "unaligned_data");
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, 32'h45, "ovf_cleared");
    chk("full_irq", 32'(key_irq), 1);
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, 32'h8000_0100 | 32'(i), "drain_data");
    end
    rd(A_STATUS, 32'h0, "drained_status");
    chk("drained_irq", 32'(key_irq), 0);

    // key 0 release: queued only when release events are enabled
    key_in = 4'b1110;
    idle(30);
    rd(A_LEVEL, 32'hE, "rel0_level");
`ifdef KEY_RELEASE_EVENT_EN
    rd(A_DATA, 32'h8000_0000, "rel0_data");
`endif
    rd(A_DATA, 32'h0, "rel0_empty");

    idle(5);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
